sa_ctrl: RTL and testbench

SA_CTRL -- requirements
Module: sa_ctrl

---
 rtl/sa_ctrl_pkg.sv | 15 +
 rtl/sa_ctrl.sv | 152 +++++++++++++++
 tb/tb_sa_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types and default sizing for the systolic-array sequencing controller.
package sa_ctrl_pkg;

   localparam int SA_N_DEF  = 4;
   localparam int SA_LW_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } sa_state_e;

endpackage

// File: rtl/sa_ctrl.sv
// Sequencer for an N x N systolic array: loads N weight rows, streams len data
// vectors, drains the pipeline for N steps and flags bottom-row result validity.
module sa_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter int N  = SA_N_DEF,
   parameter int LW = SA_LW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_v_i,
   output logic          start_ready_o,
   input  logic [LW-1:0] len_i,
   input  logic          weight_v_i,
   output logic          weight_ready_o,
   output logic [N-1:0]  wr_weight_o,
   input  logic          data_v_i,
   output logic          data_ready_o,
   input  logic          halt_i,
   output logic          step_o,
   output logic          res_v_o,
   output logic          done_o,
   output logic          busy_o
);

   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = LW + 1;
   localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);
   localparam logic [SW-1:0] RES_FIRST = SW'(N);

   sa_state_e     state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [LW-1:0] vec_cnt_q, vec_cnt_d;
   logic [SW-1:0] step_cnt_q, step_cnt_d;
   logic [SW-1:0] res_last_s;

   // Index of the last array step of the job; one bit wider than len so it never wraps.
   assign res_last_s = {1'b0, len_q} + SW'(N - 1);

   // Next-state, counter updates and handshake/step outputs.
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      row_cnt_d      = row_cnt_q;
      vec_cnt_d      = vec_cnt_q;
      step_cnt_d     = step_cnt_q;
      start_ready_o  = 1'b0;
      weight_ready_o = 1'b0;
      wr_weight_o    = {N{1'b0}};
      data_ready_o   = 1'b0;
      step_o         = 1'b0;
      res_v_o        = 1'b0;
      done_o         = 1'b0;
      busy_o         = (state_q != ST_IDLE);

      // Halt only freezes the array-facing states; IDLE and DONE keep their handshake behaviour.
      case (state_q)
         ST_IDLE: begin
            start_ready_o = 1'b1;
            if (start_v_i) begin
               len_d      = len_i;
               row_cnt_d  = {RW{1'b0}};
               vec_cnt_d  = {LW{1'b0}};
               step_cnt_d = {SW{1'b0}};
               state_d    = ST_LOAD_W;
            end else begin
               state_d    = ST_IDLE;
            end
         end

         ST_LOAD_W: begin
            weight_ready_o = ~halt_i;
            if (weight_v_i && !halt_i) begin
               wr_weight_o = N'(1'b1) << row_cnt_q;
               if (row_cnt_q == ROW_LAST) begin
                  row_cnt_d = {RW{1'b0}};
                  state_d   = (len_q == {LW{1'b0}}) ? ST_DONE : ST_STREAM;
               end else begin
                  row_cnt_d = row_cnt_q + RW'(1'b1);
               end
            end else begin
               row_cnt_d = row_cnt_q;
            end
         end

         ST_STREAM: begin
            data_ready_o = ~halt_i;
            step_o       = data_v_i & ~halt_i;
            if (step_o) begin
               vec_cnt_d  = vec_cnt_q + LW'(1'b1);
               step_cnt_d = step_cnt_q + SW'(1'b1);
               if (vec_cnt_q == (len_q - LW'(1'b1))) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_STREAM;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end

         ST_DRAIN: begin
            step_o = ~halt_i;
            if (step_o) begin
               step_cnt_d = step_cnt_q + SW'(1'b1);
               if (step_cnt_q == res_last_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               state_d = ST_DRAIN;
            end
         end

         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The first N steps only fill the array, so bottom-row results lag by N.
      if (step_o && (step_cnt_q >= RES_FIRST) && (step_cnt_q <= res_last_s)) begin
         res_v_o = 1'b1;
      end else begin
         res_v_o = 1'b0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= {LW{1'b0}};
         row_cnt_q  <= {RW{1'b0}};
         vec_cnt_q  <= {LW{1'b0}};
         step_cnt_q <= {SW{1'b0}};
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         row_cnt_q  <= row_cnt_d;
         vec_cnt_q  <= vec_cnt_d;
         step_cnt_q <= step_cnt_d;
      end
   end

endmodule

// File: tb/tb_sa_ctrl.sv
// Scoreboard bench for sa_ctrl: a driver issues jobs and queues the expected event
// stream; an independent monitor pops and compares whenever the DUT acts.
module tb_sa_ctrl;
   import sa_ctrl_pkg::*;

   localparam int N  = 4;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_v_i = 1'b0;
   logic          start_ready_o;
   logic [LW-1:0] len_i = '0;
   logic          weight_v_i = 1'b0;
   logic          weight_ready_o;
   logic [N-1:0]  wr_weight_o;
   logic          data_v_i = 1'b0;
   logic          data_ready_o;
   logic          halt_i = 1'b0;
   logic          step_o;
   logic          res_v_o;
   logic          done_o;
   logic          busy_o;

   sa_ctrl #(.N(N), .LW(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_v_i(start_v_i), .start_ready_o(start_ready_o), .len_i(len_i),
      .weight_v_i(weight_v_i), .weight_ready_o(weight_ready_o), .wr_weight_o(wr_weight_o),
      .data_v_i(data_v_i), .data_ready_o(data_ready_o), .halt_i(halt_i),
      .step_o(step_o), .res_v_o(res_v_o), .done_o(done_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // kind: 0 = weight write (val = one-hot row), 1 = array step (val = result valid), 2 = done
   typedef struct { int kind; int val; } ev_t;
   ev_t sb_q[$];

   int n_vec = 0;
   int n_miss = 0;
   int jobs_issued = 0;
   int starts_seen = 0;
   bit prev_active = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_ev(input int kind, input int val);
      ev_t e;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL sb_empty: got event kind %0d val %0h expected none at %0t", kind, val, $time);
      end else begin
         e = sb_q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_val", val, e.val);
      end
   endtask

   // Reference behaviour of one job: N row writes in order, then len+N steps of which
   // those with index N..len+N-1 carry results, then completion. len=0 skips the steps.
   task automatic push_job(input int len);
      ev_t e;
      for (int r = 0; r < N; r++) begin
         e.kind = 0; e.val = 1 << r; sb_q.push_back(e);
      end
      if (len > 0) begin
         for (int i = 0; i < len + N; i++) begin
            e.kind = 1; e.val = (i >= N && i <= len + N - 1) ? 1 : 0; sb_q.push_back(e);
         end
      end
      e.kind = 2; e.val = 0; sb_q.push_back(e);
   endtask

   // Monitor: samples settled outputs late in the cycle, away from the rising edge.
   always begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
         chk("rst_outs", 32'({step_o, res_v_o, done_o, busy_o, weight_ready_o, data_ready_o, wr_weight_o}), 32'd0);
         chk("rst_start_ready", 32'(start_ready_o), 32'd1);
         prev_active = 1'b0;
      end else begin
         chk("start_ready_vs_busy", 32'(start_ready_o), 32'(!busy_o));
         if (start_v_i && start_ready_o) starts_seen++;
         if (!busy_o || done_o)
            chk("quiet_outs", 32'({step_o, res_v_o, wr_weight_o}), 32'd0);
         if (halt_i && busy_o)
            chk("halt_gate", 32'({step_o, weight_ready_o, data_ready_o, wr_weight_o}), 32'd0);
         if (res_v_o && !step_o)
            chk("res_without_step", 32'(res_v_o), 32'd0);
         if (wr_weight_o != '0) expect_ev(0, 32'(wr_weight_o));
         if (step_o)            expect_ev(1, 32'(res_v_o));
         if (done_o) begin
            expect_ev(2, 0);
            chk("done_follows_last", 32'(prev_active), 32'd1);
         end
         prev_active = (wr_weight_o != '0) || step_o;
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 32'({step_o, res_v_o, done_o, busy_o, wr_weight_o}), 32'd0);
      chk("async_rst_ready", 32'(start_ready_o), 32'd1);
      sb_q.delete();
      start_v_i = 1'b0; weight_v_i = 1'b0; data_v_i = 1'b0; halt_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // mode: 0 random gaps/halts, 1 clean, 2 halt 5 cycles after 2 steps,
   //       3 data every other cycle, 4 reset during drain, 5 start held high
   task automatic run_job(input int len, input int mode);
      int  w_cnt = 0, d_cnt = 0, budget = 0, halt_left = 5, drain_wait = 0;
      bit  got = 1'b0, fin = 1'b0, alt = 1'b0, rst_done = 1'b0;
      push_job(len);
      jobs_issued++;
      while (!got && budget < 50) begin
         @(negedge clk);
         start_v_i = 1'b1;
         len_i = LW'(len);
         #4;
         got = start_ready_o;
         budget++;
      end
      if (!got) chk("start_accept", 32'(got), 32'd1);
      budget = 0;
      while (got && !fin && budget < 3000) begin
         @(negedge clk);
         if (mode != 5) start_v_i = 1'b0;
         len_i = LW'($urandom_range(0, 255));
         halt_i = 1'b0;
         if (mode == 0) halt_i = ($urandom_range(0, 99) < 15);
         if (mode == 2 && d_cnt >= 2 && halt_left > 0) begin
            halt_i = 1'b1;
            halt_left--;
         end
         weight_v_i = (w_cnt < N) && (mode != 0 || $urandom_range(0, 3) != 0);
         alt = !alt;
         data_v_i = (w_cnt == N) && (d_cnt < len) &&
                    ((mode == 3) ? alt : (mode != 0 || $urandom_range(0, 9) < 7));
         #4;
         if (weight_v_i && weight_ready_o) w_cnt++;
         if (data_v_i && data_ready_o) d_cnt++;
         if (done_o) fin = 1'b1;
         if (mode == 4 && w_cnt == N && d_cnt == len) begin
            drain_wait++;
            if (drain_wait == 3) begin
               apply_reset();
               fin = 1'b1;
               rst_done = 1'b1;
            end
         end
         budget++;
      end
      if (got && !fin) begin
         chk("job_timeout", 32'(fin), 32'd1);
         apply_reset();
      end
      if (mode == 2 && !rst_done) chk("halt_cycles_used", 32'(halt_left), 32'd0);
      @(negedge clk);
      start_v_i = 1'b0; weight_v_i = 1'b0; data_v_i = 1'b0; halt_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_job(3, 1);
      run_job(0, 1);
      run_job(3, 2);
      run_job(2, 3);
      run_job(1, 4);
      run_job(1, 1);
      run_job(3, 5);
      run_job(255, 1);
      for (int j = 0; j < 25; j++) run_job($urandom_range(0, 8), 0);
      @(negedge clk);
      #4;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("jobs_accepted", 32'(starts_seen), 32'(jobs_issued));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
